// File: rtl/raster_stream_tx.sv
// Raster-order frame reader: fetches IMG_W*IMG_H words from a 1-cycle-latency memory
// and streams them out through a 2-entry FIFO with valid/ready, start-of-frame and end-of-line flags.
module raster_stream_tx #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [16:0]       mem_rdata,
    output logic [16:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [ADDR_W-1:0] addr_r;
    logic              pend_r;
    logic              pend_sof_r;
    logic              pend_eol_r;
    logic [18:0]       fifo_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        cnt_r;
    logic              done_r;

    logic              issue_s;
    logic              pop_s;
    logic              credit_s;
    logic              last_col_s;
    logic              last_rd_s;
    logic              final_s;

    // Issue/transition decisions; the credit check counts this cycle's pop so a
    // 2-entry FIFO still sustains one pixel per cycle.
    always_comb begin
        state_s    = state_r;
        issue_s    = 1'b0;
        pop_s      = (cnt_r != 2'd0) & out_ready;
        credit_s   = (({1'b0, cnt_r} + {2'b00, pend_r}) < (3'd2 + {2'b00, pop_s}));
        last_col_s = (col_r == CW'(IMG_W - 1));
        last_rd_s  = last_col_s && (row_r == RW'(IMG_H - 1));
        final_s    = (state_r == DRAIN) && pop_s && (cnt_r == 2'd1) && !pend_r;
        case (state_r)
            IDLE: begin
                if (start && !rst) begin
                    issue_s = 1'b1;
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (credit_s && !rst) begin
                    issue_s = 1'b1;
                    if (last_rd_s) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = FETCH;
                end
            end
            DRAIN: begin
                if (final_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Raster counters; wrap to zero once the last read is issued so the next frame starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= {ADDR_W{1'b0}};
            col_r  <= {CW{1'b0}};
            row_r  <= {RW{1'b0}};
        end else if (issue_s) begin
            if (last_rd_s) begin
                addr_r <= {ADDR_W{1'b0}};
                col_r  <= {CW{1'b0}};
                row_r  <= {RW{1'b0}};
            end else begin
                addr_r <= addr_r + ADDR_W'(1);
                col_r  <= last_col_s ? {CW{1'b0}} : col_r + CW'(1);
                row_r  <= last_col_s ? row_r + RW'(1) : row_r;
            end
        end
    end

    // In-flight read tag: flags are captured at issue and travel with the returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r     <= 1'b0;
            pend_sof_r <= 1'b0;
            pend_eol_r <= 1'b0;
        end else begin
            pend_r     <= issue_s;
            pend_sof_r <= (row_r == {RW{1'b0}}) && (col_r == {CW{1'b0}});
            pend_eol_r <= last_col_s;
        end
    end

    // Two-entry output FIFO; concurrent write and pop keep order via separate pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_r[0] <= 19'd0;
            fifo_r[1] <= 19'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
        end else begin
            if (pend_r) begin
                fifo_r[wr_ptr_r] <= {pend_sof_r, pend_eol_r, mem_rdata};
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= cnt_r + {1'b0, pend_r} - {1'b0, pop_s};
        end
    end

    // End-of-frame pulse, one cycle after the last pixel leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= final_s;
        end
    end

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign mem_rd    = issue_s;
    assign mem_addr  = addr_r;
    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = fifo_r[rd_ptr_r][16:0];
    assign out_eol   = fifo_r[rd_ptr_r][17];
    assign out_sof   = fifo_r[rd_ptr_r][18];

endmodule

// File: doc/raster_stream_tx.md
RASTER_STREAM_TX -- requirements
Module: raster_stream_tx

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning pixels per line (2..4096).
REQ-002 SHALL have parameter IMG_H, default 8, meaning lines per frame (1..4096).
REQ-003 SHALL have parameter ADDR_W, default 16, meaning memory address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, single-cycle frame start request.
REQ-007 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at end of frame.
REQ-009 SHALL have port mem_rd, output, 1, read strobe to frame memory.
REQ-010 SHALL have port mem_addr, output, ADDR_W, read address, row-major, base 0.
REQ-011 SHALL have port mem_rdata, input, 17, read data, valid exactly 1 cycle after mem_rd.
REQ-012 SHALL have port out_data, output, 17, pixel value to downstream pipeline.
REQ-013 SHALL have port out_valid, output, 1, out_data/out_sof/out_eol valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts; transfer = out_valid & out_ready.
REQ-015 SHALL have port out_sof, output, 1, high with the first pixel of a frame.
REQ-016 SHALL have port out_eol, output, 1, high with the last pixel of each line.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after the read of address IMG_W*IMG_H-1 is issued; DRAIN->IDLE on the final pixel transfer.
REQ-018 SHALL ignore start while busy; busy = (state != IDLE).
REQ-019 SHALL issue reads at addresses 0,1,...,IMG_W*IMG_H-1 in order, each exactly once per frame.
REQ-020 SHALL hold a 2-entry output FIFO; mem_rd asserted in FETCH only when (FIFO occupancy + reads in flight) < 2, so no read data is ever dropped.
REQ-021 SHALL write mem_rdata into the FIFO the cycle after each mem_rd, tagged with sof/eol flags computed from the column/row counters at issue time.
REQ-022 SHALL present the FIFO head on out_data/out_sof/out_eol with out_valid = FIFO non-empty.
REQ-023 SHALL keep out_data, out_sof, out_eol stable while out_valid & !out_ready.
REQ-024 SHALL sustain one pixel per cycle when out_ready is held high (after a 2-cycle start-up latency: start in cycle 0, first out_valid in cycle 2).
REQ-025 SHALL assert out_sof on pixel (row 0, col 0) only and out_eol on every col IMG_W-1.
REQ-026 SHALL handle simultaneous FIFO write and read in one cycle without loss or reordering.
REQ-027 SHALL pulse done for exactly one cycle, the cycle after the final pixel transfer; busy is low in that same cycle.
REQ-028 SHALL accept a start in the done cycle and begin a new frame at address 0.
REQ-029 SHALL never drive mem_addr outside 0..IMG_W*IMG_H-1 while mem_rd is high.

Reset
REQ-030 SHALL on rst force state IDLE, counters 0, FIFO empty, in-flight cleared; busy, done, mem_rd, out_valid, out_sof, out_eol = 0; out_data, mem_addr = 0.
REQ-031 SHALL on rst mid-frame abandon the frame; no done pulse; a read returning the cycle after reset release is discarded.

Verification
REQ-032 SHALL be verified: IMG_W=4, IMG_H=2, mem[a]=a+0x100, out_ready=1, start at cycle 0 -> out_data 0x100..0x107 in cycles 2..9, sof at 0x100, eol at 0x103 and 0x107, done at cycle 10.
REQ-033 SHALL be verified: out_ready toggled 1,0,0,1 repeating -> identical ordered 8-pixel sequence, out_data stable during every stall, mem_rd never issued with 2 entries occupied/in flight.
REQ-034 SHALL be verified: start pulsed at cycles 0 and 3 -> exactly one frame, 8 reads, one done.
REQ-035 SHALL be verified: rst asserted after 3 pixel transfers -> all outputs 0 immediately, no done; next start yields 0x100 with sof.
REQ-036 SHALL be verified: start in the done cycle -> second frame follows back-to-back with addresses restarting at 0.
REQ-037 SHALL be verified: out_ready=0 for 20 cycles after start -> exactly 2 reads issued, out_data=0x100 held, then normal completion once out_ready=1.
